// File: rtl/river_move_sequencer.sv
// Replays a stored program of river-crossing boat moves as one-hot w/g/c selects and tracks shadow banks.
// Optional build macro AUTO_SOLVE_EN preloads the canonical seven-move solution at reset.
module river_move_sequencer #(
   parameter int MAX_MOVES = 8,
   parameter int PTR_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [PTR_W-1:0] load_addr,
   input  logic [1:0]       load_data,
   input  logic [PTR_W:0]   num_moves,
   input  logic             start,
   output logic             w,
   output logic             g,
   output logic             c,
   output logic             bank_w,
   output logic             bank_g,
   output logic             bank_c,
   output logic             bank_p,
   output logic [PTR_W:0]   move_idx,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       err_code
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_FAIL} state_t;

   localparam logic [PTR_W:0] MAX_CNT = (PTR_W+1)'(MAX_MOVES);

   generate
      if (MAX_MOVES < 1) begin : g_depth_check
         $error("MAX_MOVES must be at least 1");
      end
`ifdef AUTO_SOLVE_EN
      if (MAX_MOVES < 7) begin : g_auto_check
         $error("AUTO_SOLVE_EN needs MAX_MOVES >= 7");
      end
`endif
   endgenerate

   // Program slot contents after reset: canonical solution or all person-alone.
   function automatic logic [1:0] reset_code(input int slot);
`ifdef AUTO_SOLVE_EN
      case (slot)
         32'sd0:  reset_code = 2'd2;
         32'sd1:  reset_code = 2'd0;
         32'sd2:  reset_code = 2'd1;
         32'sd3:  reset_code = 2'd2;
         32'sd4:  reset_code = 2'd3;
         32'sd5:  reset_code = 2'd0;
         32'sd6:  reset_code = 2'd2;
         default: reset_code = 2'd0;
      endcase
`else
      reset_code = (slot >= 32'sd0) ? 2'd0 : 2'd0;
`endif
   endfunction

   state_t           state_r, state_s;
   logic [1:0]       prog_r [MAX_MOVES];
   logic [3:0]       banks_r, banks_s;     // {w, g, c, p}
   logic [PTR_W:0]   idx_r, idx_s;
   logic [PTR_W:0]   count_r, count_s;
   logic [1:0]       err_r, err_s;
   logic [2:0]       sel_s;                // {w, g, c}
   logic [1:0]       code_s;
   logic [3:0]       moved_s;
   logic             illegal_s;
   logic             unsafe_s;
   logic             idle_like_s;

   assign idle_like_s = (state_r != ST_RUN);

   // Decode the current program slot into a one-hot item select while replaying.
   always_comb begin
      code_s = 2'd0;
      sel_s  = 3'b000;
      if (state_r == ST_RUN) begin
         code_s = prog_r[idx_r[PTR_W-1:0]];
         case (code_s)
            2'd1:    sel_s = 3'b100;
            2'd2:    sel_s = 3'b010;
            2'd3:    sel_s = 3'b001;
            default: sel_s = 3'b000;
         endcase
      end else begin
         code_s = 2'd0;
         sel_s  = 3'b000;
      end
   end

   // Next-state, bank update and error classification.
   always_comb begin
      state_s   = state_r;
      banks_s   = banks_r;
      idx_s     = idx_r;
      count_s   = count_r;
      err_s     = err_r;
      moved_s   = 4'b0000;
      illegal_s = 1'b0;
      unsafe_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            // An item crosses only when it stands on the person's side.
            moved_s   = {sel_s[2] & (banks_r[3] == banks_r[0]),
                         sel_s[1] & (banks_r[2] == banks_r[0]),
                         sel_s[0] & (banks_r[1] == banks_r[0]),
                         1'b1};
            illegal_s = (sel_s[2] & (banks_r[3] != banks_r[0])) |
                        (sel_s[1] & (banks_r[2] != banks_r[0])) |
                        (sel_s[0] & (banks_r[1] != banks_r[0]));
            banks_s   = banks_r ^ moved_s;
            unsafe_s  = ((banks_s[3] == banks_s[2]) && (banks_s[2] != banks_s[0])) ||
                        ((banks_s[2] == banks_s[1]) && (banks_s[2] != banks_s[0]));
            idx_s     = idx_r + (PTR_W+1)'(1);
            if (illegal_s) begin
               state_s = ST_FAIL;
               err_s   = 2'd1;
            end else if (unsafe_s) begin
               state_s = ST_FAIL;
               err_s   = 2'd2;
            end else if (idx_s == count_r) begin
               if (banks_s == 4'b1111) begin
                  state_s = ST_DONE;
                  err_s   = 2'd0;
               end else begin
                  state_s = ST_FAIL;
                  err_s   = 2'd3;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               banks_s = 4'b0000;
               idx_s   = '0;
               count_s = (num_moves > MAX_CNT) ? MAX_CNT : num_moves;
               if (count_s == '0) begin
                  state_s = ST_FAIL;
                  err_s   = 2'd3;
               end else begin
                  state_s = ST_RUN;
                  err_s   = 2'd0;
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            err_s   = 2'd0;
         end
      endcase
   end

   // Sequencer state, shadow banks and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         banks_r <= 4'b0000;
         idx_r   <= '0;
         count_r <= '0;
         err_r   <= 2'd0;
      end else begin
         state_r <= state_s;
         banks_r <= banks_s;
         idx_r   <= idx_s;
         count_r <= count_s;
         err_r   <= err_s;
      end
   end

   // Program memory; writes are locked out while a replay is running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_MOVES; i++) begin
            prog_r[i] <= reset_code(i);
         end
      end else if (load_en && idle_like_s) begin
         prog_r[load_addr] <= load_data;
      end else begin
         prog_r <= prog_r;
      end
   end

   assign {w, g, c}                       = sel_s;
   assign {bank_w, bank_g, bank_c, bank_p} = banks_r;
   assign move_idx                        = idx_r;
   assign busy                            = (state_r == ST_RUN);
   assign done                            = (state_r == ST_DONE);
   assign error                           = (state_r == ST_FAIL);
   assign err_code                        = err_r;

endmodule

// File: tb/tb_river_move_sequencer.sv
// Randomised bench for river_move_sequencer against a puzzle-rule reference model.
// Tracks AUTO_SOLVE_EN so the model's reset program matches the build.
module tb_river_move_sequencer;

   localparam int MAX_MOVES = 8;
   localparam int PTR_W     = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load_en;
   logic [PTR_W-1:0] load_addr;
   logic [1:0]       load_data;
   logic [PTR_W:0]   num_moves;
   logic             start;
   logic             w, g, c;
   logic             bank_w, bank_g, bank_c, bank_p;
   logic [PTR_W:0]   move_idx;
   logic             busy, done, error;
   logic [1:0]       err_code;

   river_move_sequencer #(.MAX_MOVES(MAX_MOVES), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .num_moves(num_moves), .start(start),
      .w(w), .g(g), .c(c), .bank_w(bank_w), .bank_g(bank_g), .bank_c(bank_c),
      .bank_p(bank_p), .move_idx(move_idx), .busy(busy), .done(done),
      .error(error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: program copy, positions of wolf/goat/cabbage/person, moves issued.
   int mprog [MAX_MOVES];
   int pos [4];
   int midx;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sel_of(input int code);
      case (code)
         1:       return 4;
         2:       return 2;
         3:       return 1;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      int canon [7] = '{2, 0, 1, 2, 3, 0, 2};
      for (int i = 0; i < MAX_MOVES; i++) begin
`ifdef AUTO_SOLVE_EN
         mprog[i] = (i < 7) ? canon[i] : 0;
`else
         mprog[i] = (canon[0] == 2) ? 0 : 0;
`endif
      end
      for (int i = 0; i < 4; i++) pos[i] = 0;
      midx = 0;
   endtask

   task automatic check_outs(input string ph, input int busy_e, input int done_e,
                             input int err_e, input int code_e, input int sel_e);
      chk({ph, ".busy"}, int'(busy), busy_e);
      chk({ph, ".done"}, int'(done), done_e);
      chk({ph, ".error"}, int'(error), err_e);
      chk({ph, ".err_code"}, int'(err_code), code_e);
      chk({ph, ".wgc"}, int'({w, g, c}), sel_e);
      chk({ph, ".banks"}, int'({bank_w, bank_g, bank_c, bank_p}),
          pos[0] * 8 + pos[1] * 4 + pos[2] * 2 + pos[3]);
      chk({ph, ".move_idx"}, int'(move_idx), midx);
   endtask

   task automatic load_all(input logic [15:0] packed_prog);
      for (int i = 0; i < MAX_MOVES; i++) begin
         load_en   = 1'b1;
         load_addr = PTR_W'(i);
         load_data = packed_prog[2*i +: 2];
         mprog[i]  = int'(packed_prog[2*i +: 2]);
         tick();
      end
      load_en = 1'b0;
   endtask

   // Start a replay and follow it to completion, checking every cycle.
   task automatic run(input int num, input bit extra_load, input bit noise);
      int cnt, code, it, code_e;
      bit illegal, unsafe, fin, done_e;
      cnt = (num > MAX_MOVES) ? MAX_MOVES : num;
      start     = 1'b1;
      num_moves = 4'(num);
      if (extra_load) begin
         load_en   = 1'b1;
         load_addr = PTR_W'($urandom_range(0, MAX_MOVES - 1));
         load_data = 2'($urandom_range(0, 3));
         mprog[load_addr] = int'(load_data);
      end
      tick();
      start   = 1'b0;
      load_en = 1'b0;
      for (int i = 0; i < 4; i++) pos[i] = 0;
      midx   = 0;
      fin    = (cnt == 0);
      done_e = 1'b0;
      code_e = 3;
      while (!fin) begin
         code = mprog[midx];
         check_outs("run", 1, 0, 0, 0, sel_of(code));
         if (noise) begin
            start     = 1'b1;
            num_moves = 4'($urandom_range(0, 15));
            load_en   = 1'b1;
            load_addr = PTR_W'($urandom_range(0, MAX_MOVES - 1));
            load_data = 2'($urandom_range(0, 3));
         end
         illegal = 1'b0;
         if (code != 0) begin
            it = code - 1;
            if (pos[it] != pos[3]) illegal = 1'b1;
            else pos[it] = 1 - pos[3];
         end
         pos[3] = 1 - pos[3];
         midx++;
         unsafe = ((pos[0] == pos[1]) && (pos[1] != pos[3])) ||
                  ((pos[1] == pos[2]) && (pos[1] != pos[3]));
         tick();
         start   = 1'b0;
         load_en = 1'b0;
         if (illegal) begin
            fin = 1'b1; code_e = 1;
         end else if (unsafe) begin
            fin = 1'b1; code_e = 2;
         end else if (midx == cnt) begin
            fin = 1'b1;
            if (pos[0] + pos[1] + pos[2] + pos[3] == 4) begin
               done_e = 1'b1; code_e = 0;
            end else begin
               code_e = 3;
            end
         end
      end
      check_outs("end", 0, int'(done_e), int'(!done_e), code_e, 0);
      tick();
      check_outs("hold", 0, int'(done_e), int'(!done_e), code_e, 0);
   endtask

   initial begin
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      num_moves = '0; start = 1'b0;
      model_reset();
      #12;
      check_outs("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      check_outs("idle", 0, 0, 0, 0, 0);

      load_all(16'h2392); run(7, 1'b0, 1'b0);   // canonical solution -> DONE
      load_all(16'h0001); run(1, 1'b0, 1'b0);   // wolf first -> unsafe
      load_all(16'h0006); run(2, 1'b0, 1'b0);   // wolf on wrong side -> illegal
      run(0, 1'b0, 1'b0);                       // empty program
      load_all(16'h0002); run(2, 1'b0, 1'b0);   // incomplete
      load_all(16'hAAAA); run(15, 1'b0, 1'b0);  // clamps to 8 moves, incomplete
      load_all(16'h2392); run(7, 1'b0, 1'b1);   // start/load during RUN ignored

      // Reset in the middle of a replay.
      load_all(16'h2392);
      start = 1'b1; num_moves = 4'd7;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("mid.wgc", int'({w, g, c}), 2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outs("abort", 0, 0, 0, 0, 0);
      #3 rst_n = 1'b1;
      tick();
      run(3, 1'b0, 1'b0);                       // program as left by reset
      load_all(16'h2392); run(7, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         load_all(16'($urandom));
         run($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
